// File: rtl/mul_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : mul_seq_ctrl_if
// Brief   : Request/result handshake and DSP multiplier port bundle.
// Revision: 1.0
// ============================================================================
interface mul_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        kill;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_signa;
    logic        mul_signb;
    logic        mul_en;
    logic [31:0] mul_p;

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, kill, out_ready, mul_p,
        output in_ready, busy, out_valid, out_result,
               mul_a, mul_b, mul_signa, mul_signb, mul_en
    );

    modport master (
        output in_valid, in_op, in_src1, in_src2, kill, out_ready, mul_p,
        input  in_ready, busy, out_valid, out_result,
               mul_a, mul_b, mul_signa, mul_signb, mul_en
    );
endinterface
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mul_seq_ctrl
// Brief   : 32x32 multiply sequenced as four 16x16 partial products on one
//           shared pipelined multiplier cell, accumulated into 64 bits.
// Revision: 1.0
// ============================================================================
module mul_seq_ctrl #(
    parameter int MUL_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mul_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_step;
    logic [1:0]             r_op;
    logic [31:0]            r_src1;
    logic [31:0]            r_src2;
    logic [63:0]            r_acc;
    logic [MUL_LAT-1:0]     r_tag_vld;
    logic [2*MUL_LAT-1:0]   r_tag_k;

    logic                   w_accept;
    logic                   w_kill;
    logic                   w_s1;
    logic                   w_s2;
    logic                   w_tag_in_vld;
    logic [MUL_LAT-1:0]     w_vld_shift;
    logic [2*MUL_LAT-1:0]   w_k_shift;
    logic                   w_out_vld;
    logic [1:0]             w_out_k;
    logic                   w_last;
    logic                   w_step_sign;
    logic [63:0]            w_ext;
    logic [63:0]            w_addend;
    logic                   w_mul_en;
    logic [15:0]            w_mul_a;
    logic [15:0]            w_mul_b;
    logic                   w_signa;
    logic                   w_signb;

    assign w_accept     = bus.in_valid & (r_state == S_IDLE);
    assign w_kill       = bus.kill & (r_state != S_IDLE);
    assign w_s1         = (r_op == 2'b01) | (r_op == 2'b10);
    assign w_s2         = (r_op == 2'b01);
    assign w_tag_in_vld = (r_state == S_ISSUE);

    generate
        if (MUL_LAT == 1) begin : g_tag_single
            assign w_vld_shift = w_tag_in_vld;
            assign w_k_shift   = r_step;
        end else begin : g_tag_multi
            assign w_vld_shift = {r_tag_vld[MUL_LAT-2:0], w_tag_in_vld};
            assign w_k_shift   = {r_tag_k[2*MUL_LAT-3:0], r_step};
        end
    endgenerate

    // Tag at the pipe output only counts while an operation is in flight,
    // so stale products left in the cell after kill/reset are never summed.
    assign w_out_vld = r_tag_vld[MUL_LAT-1] & ((r_state == S_ISSUE) | (r_state == S_DRAIN));
    assign w_out_k   = r_tag_k[2*MUL_LAT-1 -: 2];
    assign w_last    = w_out_vld & (w_out_k == 2'd3);

    always_comb begin
        w_step_sign = 1'b0;
        case (w_out_k)
            2'd0:    w_step_sign = 1'b0;
            2'd1:    w_step_sign = w_s2;
            2'd2:    w_step_sign = w_s1;
            default: w_step_sign = w_s1 | w_s2;
        endcase
    end

    assign w_ext    = w_step_sign ? {{32{bus.mul_p[31]}}, bus.mul_p} : {32'd0, bus.mul_p};
    assign w_addend = (w_out_k == 2'd0) ? w_ext :
                      (w_out_k == 2'd3) ? (w_ext << 32) : (w_ext << 16);

    always_comb begin
        w_state_nxt = r_state;
        w_mul_en    = 1'b0;
        w_mul_a     = 16'd0;
        w_mul_b     = 16'd0;
        w_signa     = 1'b0;
        w_signb     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_mul_en = 1'b1;
                w_mul_a  = r_step[1] ? r_src1[31:16] : r_src1[15:0];
                w_mul_b  = r_step[0] ? r_src2[31:16] : r_src2[15:0];
                w_signa  = r_step[1] & w_s1;
                w_signb  = r_step[0] & w_s2;
                if (r_step == 2'd3) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // The cycle that consumes the last product needs no further advance.
                w_mul_en = ~w_last;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_kill) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_step    <= 2'd0;
            r_op      <= 2'd0;
            r_src1    <= 32'd0;
            r_src2    <= 32'd0;
            r_acc     <= 64'd0;
            r_tag_vld <= '0;
            r_tag_k   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_kill) begin
                r_step    <= 2'd0;
                r_acc     <= 64'd0;
                r_tag_vld <= '0;
                r_tag_k   <= '0;
            end else if (w_accept) begin
                r_step <= 2'd0;
                r_op   <= bus.in_op;
                r_src1 <= bus.in_src1;
                r_src2 <= bus.in_src2;
                r_acc  <= 64'd0;
            end else begin
                if (r_state == S_ISSUE) r_step <= r_step + 2'd1;
                if (w_out_vld) r_acc <= r_acc + w_addend;
                if (w_last) begin
                    r_tag_vld <= '0;
                    r_tag_k   <= '0;
                end else if (w_mul_en) begin
                    r_tag_vld <= w_vld_shift;
                    r_tag_k   <= w_k_shift;
                end
            end
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.out_result = (r_state != S_DONE) ? 32'd0 :
                            (r_op == 2'b00)     ? r_acc[31:0] : r_acc[63:32];
    assign bus.mul_en     = w_mul_en;
    assign bus.mul_a      = w_mul_a;
    assign bus.mul_b      = w_mul_b;
    assign bus.mul_signa  = w_signa;
    assign bus.mul_signb  = w_signb;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_seq_ctrl
// Brief   : Drives MUL_LAT=1 and MUL_LAT=3 sequencers in lockstep against a
//           cycle-level behavioural model plus directed literal results.
// Revision: 1.0
// ============================================================================
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        kill;
    logic        out_ready;

    mul_seq_ctrl_if bus1();
    mul_seq_ctrl_if bus3();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_op     = in_op;
    assign bus1.in_src1   = in_src1;
    assign bus1.in_src2   = in_src2;
    assign bus1.kill      = kill;
    assign bus1.out_ready = out_ready;
    assign bus3.in_valid  = in_valid;
    assign bus3.in_op     = in_op;
    assign bus3.in_src1   = in_src1;
    assign bus3.in_src2   = in_src2;
    assign bus3.kill      = kill;
    assign bus3.out_ready = out_ready;

    mul_seq_ctrl #(.MUL_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    mul_seq_ctrl #(.MUL_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    // Shared DSP cell model: signed/unsigned 16x16, pipeline advances on mul_en.
    function automatic logic [31:0] dsp(input logic [15:0] a, input logic [15:0] b,
                                        input logic sa, input logic sb);
        logic signed [33:0] p;
        p = $signed({sa & a[15], a}) * $signed({sb & b[15], b});
        return p[31:0];
    endfunction

    logic [31:0] p1 = 32'd0;
    logic [31:0] p3 [3] = '{32'd0, 32'd0, 32'd0};
    always @(posedge clk) begin
        if (bus1.mul_en) p1 <= dsp(bus1.mul_a, bus1.mul_b, bus1.mul_signa, bus1.mul_signb);
        if (bus3.mul_en) begin
            p3[0] <= dsp(bus3.mul_a, bus3.mul_b, bus3.mul_signa, bus3.mul_signb);
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end
    assign bus1.mul_p = p1;
    assign bus3.mul_p = p3[2];

    logic        obs_ir   [2];
    logic        obs_busy [2];
    logic        obs_ov   [2];
    logic        obs_en   [2];
    logic        obs_sa   [2];
    logic        obs_sb   [2];
    logic [15:0] obs_a    [2];
    logic [15:0] obs_b    [2];
    logic [31:0] obs_res  [2];
    assign obs_ir[0] = bus1.in_ready;   assign obs_ir[1] = bus3.in_ready;
    assign obs_busy[0] = bus1.busy;     assign obs_busy[1] = bus3.busy;
    assign obs_ov[0] = bus1.out_valid;  assign obs_ov[1] = bus3.out_valid;
    assign obs_en[0] = bus1.mul_en;     assign obs_en[1] = bus3.mul_en;
    assign obs_sa[0] = bus1.mul_signa;  assign obs_sa[1] = bus3.mul_signa;
    assign obs_sb[0] = bus1.mul_signb;  assign obs_sb[1] = bus3.mul_signb;
    assign obs_a[0] = bus1.mul_a;       assign obs_a[1] = bus3.mul_a;
    assign obs_b[0] = bus1.mul_b;       assign obs_b[1] = bus3.mul_b;
    assign obs_res[0] = bus1.out_result; assign obs_res[1] = bus3.out_result;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Model: per instance, cycles elapsed since accept decide every output.
    bit          m_act [2];
    int          m_age [2];
    logic [1:0]  m_op  [2];
    logic [31:0] m_a   [2];
    logic [31:0] m_b   [2];
    logic [31:0] m_res [2];

    task automatic model_cmp();
        int L, c, k;
        bit en, ov, esa, esb;
        logic [15:0] ea, eb;
        string tag;
        for (int i = 0; i < 2; i++) begin
            L   = (i == 0) ? 1 : 3;
            tag = (i == 0) ? "L1" : "L3";
            c   = m_age[i];
            en  = m_act[i] && c >= 1 && c <= L + 3;
            ov  = m_act[i] && c >= L + 5;
            ea = 16'd0; eb = 16'd0; esa = 1'b0; esb = 1'b0;
            if (m_act[i] && c >= 1 && c <= 4) begin
                k   = c - 1;
                ea  = (k >= 2) ? m_a[i][31:16] : m_a[i][15:0];
                eb  = (k % 2 == 1) ? m_b[i][31:16] : m_b[i][15:0];
                esa = (k >= 2) && (m_op[i] == 2'b01 || m_op[i] == 2'b10);
                esb = (k % 2 == 1) && (m_op[i] == 2'b01);
            end
            chk({tag, " in_ready"}, obs_ir[i], !m_act[i]);
            chk({tag, " busy"}, obs_busy[i], m_act[i]);
            chk({tag, " out_valid"}, obs_ov[i], ov);
            chk({tag, " mul_en"}, obs_en[i], en);
            if (m_act[i] && c >= 1 && c <= L + 4) begin
                chk({tag, " mul_a"}, obs_a[i], ea);
                chk({tag, " mul_b"}, obs_b[i], eb);
                chk({tag, " mul_signs"}, {obs_sa[i], obs_sb[i]}, {esa, esb});
            end
            if (ov) chk({tag, " out_result"}, obs_res[i], m_res[i]);
            if (reset) m_act[i] = 1'b0;
            else if (!m_act[i]) begin
                if (in_valid) begin
                    m_act[i] = 1'b1;
                    m_age[i] = 1;
                    m_op[i]  = in_op;
                    m_a[i]   = in_src1;
                    m_b[i]   = in_src2;
                    m_res[i] = ref_mul(in_op, in_src1, in_src2);
                end
            end else if (kill || (ov && out_ready)) m_act[i] = 1'b0;
            else m_age[i]++;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Caller is at the start of a cycle with both DUTs idle; returns at the
    // start of the first cycle where both are idle again.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm, input int hold);
        int t1, t3, n1, n3;
        logic [31:0] r1, r3;
        t1 = -1; t3 = -1; n1 = 0; n3 = 0; r1 = 32'd0; r3 = 32'd0;
        chk({nm, " model"}, ref_mul(op, a, b), exp);
        out_ready = (hold == 0);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
        sample();
        chk({nm, " idle L1"}, {obs_ir[0], obs_busy[0], obs_ov[0]}, 3'b100);
        chk({nm, " idle L3"}, {obs_ir[1], obs_busy[1], obs_ov[1]}, 3'b100);
        advance();
        in_valid = 1'b0; in_op = 2'($urandom); in_src1 = $urandom; in_src2 = $urandom;
        for (int c = 1; c <= 20 && (t1 < 0 || t3 < 0); c++) begin
            sample();
            if (obs_en[0]) n1++;
            if (obs_en[1]) n3++;
            if (obs_ov[0] && t1 < 0) begin t1 = c; r1 = obs_res[0]; end
            if (obs_ov[1] && t3 < 0) begin t3 = c; r3 = obs_res[1]; end
            advance();
        end
        chk({nm, " latency L1"}, t1, 6);
        chk({nm, " latency L3"}, t3, 8);
        chk({nm, " mul_en cycles L1"}, n1, 4);
        chk({nm, " mul_en cycles L3"}, n3, 6);
        chk({nm, " result L1"}, r1, exp);
        chk({nm, " result L3"}, r3, exp);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                sample();
                chk({nm, " hold valid"}, {obs_ov[0], obs_ov[1]}, 2'b11);
                chk({nm, " hold ready"}, {obs_ir[0], obs_ir[1]}, 2'b00);
                chk({nm, " hold result"}, {obs_res[0], obs_res[1]}, {exp, exp});
                advance();
            end
            out_ready = 1'b1;
            sample();
            advance();
            sample();
            chk({nm, " ready after handoff"}, {obs_ir[0], obs_ir[1]}, 2'b11);
            advance();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_src1 = 32'd0; in_src2 = 32'd0;
        kill = 1'b0; out_ready = 1'b1;
        advance(); advance();
        sample();
        chk("reset ctrl L1", {obs_ir[0], obs_busy[0], obs_ov[0], obs_en[0]}, 4'b1000);
        chk("reset ctrl L3", {obs_ir[1], obs_busy[1], obs_ov[1], obs_en[1]}, 4'b1000);
        chk("reset data", {obs_res[0], obs_res[1], obs_a[0], obs_b[0], obs_a[1], obs_b[1]}, '0);
        advance();
        reset = 1'b0;

        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULXUU ffff*ffff", 0);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "MUL ffff*ffff", 0);
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULXSS min*min", 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "MULXSS -1*2", 0);
        do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULXSU -1*max", 0);
        do_op(2'b11, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, "MULXUU 10001^2", 0);
        do_op(2'b00, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, "MUL 10001^2 backpressure", 10);

        // kill in cycle 3, then an immediate MUL 3*5 in cycle 4
        in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'h1234_5678; in_src2 = 32'h9ABC_DEF0;
        sample(); advance();
        in_valid = 1'b0;
        sample(); advance();
        sample(); advance();
        kill = 1'b1;
        sample(); advance();
        kill = 1'b0;
        do_op(2'b00, 32'd3, 32'd5, 32'h0000_000F, "MUL 3*5 after kill", 0);

        // reset in cycle 5, where both instances are draining
        in_valid = 1'b1; in_op = 2'b11; in_src1 = 32'hDEAD_BEEF; in_src2 = 32'hCAFE_F00D;
        sample(); advance();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin sample(); advance(); end
        reset = 1'b1;
        sample(); advance();
        reset = 1'b0;
        sample();
        chk("mid-op reset ctrl L1", {obs_ir[0], obs_busy[0], obs_ov[0], obs_en[0], obs_sa[0], obs_sb[0]}, 6'b100000);
        chk("mid-op reset ctrl L3", {obs_ir[1], obs_busy[1], obs_ov[1], obs_en[1], obs_sa[1], obs_sb[1]}, 6'b100000);
        chk("mid-op reset data", {obs_res[0], obs_res[1], obs_a[0], obs_b[0], obs_a[1], obs_b[1]}, '0);
        advance();
        do_op(2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "MULXUU after reset", 0);

        // random traffic with backpressure, kill and occasional reset
        for (int n = 0; n < 4000; n++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_op     = 2'($urandom);
            in_src1   = pick();
            in_src2   = pick();
            kill      = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 599) == 0);
            sample(); advance();
        end
        in_valid = 1'b0; kill = 1'b0; reset = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin sample(); advance(); end
        chk("final idle", {obs_ir[0], obs_ir[1], obs_busy[0], obs_busy[1]}, 4'b1100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
